// File: rtl/wb_regfile.sv
// Writeback-stage register file: 31 stored registers (r1..r31), two combinational
// read ports, one write port fed by the MEM/WB writeback mux, and a commit counter.
// Optional same-cycle write-to-read bypass is enabled by defining WB_BYPASS_EN.
module wb_regfile (
  input  logic        clk,
  input  logic        clrn,
  input  logic        wwreg,
  input  logic        wm2reg,
  input  logic [31:0] walu,
  input  logic [31:0] wmo,
  input  logic [4:0]  wrn,
  input  logic [4:0]  rna,
  input  logic [4:0]  rnb,
  output logic [31:0] qa,
  output logic [31:0] qb,
  output logic [31:0] wdata,
  output logic [31:0] wcnt
);

  // r0 is hardwired to zero, so only r1..r31 exist as storage
  logic [31:0] rf_q [31:1];
  logic [31:0] wcnt_q;
  logic        commit;

  // Writeback source select, visible regardless of wwreg for forwarding
  always_comb begin
    wdata = wm2reg ? wmo : walu;
  end

  // A write commits only when enabled and not aimed at r0
  always_comb begin
    commit = wwreg && (wrn != 5'd0);
  end

  // Register storage and commit counter; reset clears everything immediately
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      for (int i = 1; i < 32; i++) begin
        rf_q[i] <= '0;
      end
      wcnt_q <= '0;
    end else if (commit) begin
      rf_q[wrn] <= wdata;
      wcnt_q    <= wcnt_q + 32'd1;
    end
  end

  // Read port A; clrn gating keeps reads at zero while reset is held
  always_comb begin
    qa = '0;
    if (clrn && (rna != 5'd0)) begin
`ifdef WB_BYPASS_EN
      if (commit && (rna == wrn)) begin
        qa = wdata;
      end else begin
        qa = rf_q[rna];
      end
`else
      qa = rf_q[rna];
`endif
    end
  end

  // Read port B, same rules as port A
  always_comb begin
    qb = '0;
    if (clrn && (rnb != 5'd0)) begin
`ifdef WB_BYPASS_EN
      if (commit && (rnb == wrn)) begin
        qb = wdata;
      end else begin
        qb = rf_q[rnb];
      end
`else
      qb = rf_q[rnb];
`endif
    end
  end

  // Counter output
  always_comb begin
    wcnt = wcnt_q;
  end

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: directed scenarios plus randomized traffic
// compared against an array-based reference model of the register file.
module tb_wb_regfile;

  logic        clk;
  logic        clrn;
  logic        wwreg;
  logic        wm2reg;
  logic [31:0] walu;
  logic [31:0] wmo;
  logic [4:0]  wrn;
  logic [4:0]  rna;
  logic [4:0]  rnb;
  logic [31:0] qa;
  logic [31:0] qb;
  logic [31:0] wdata;
  logic [31:0] wcnt;

  int unsigned checks;
  int unsigned failures;

  // Reference model: 32 architectural registers (entry 0 never written) and a counter
  logic [31:0] model_rf [32];
  logic [31:0] model_cnt;

  wb_regfile dut (
    .clk    (clk),
    .clrn   (clrn),
    .wwreg  (wwreg),
    .wm2reg (wm2reg),
    .walu   (walu),
    .wmo    (wmo),
    .wrn    (wrn),
    .rna    (rna),
    .rnb    (rnb),
    .qa     (qa),
    .qb     (qb),
    .wdata  (wdata),
    .wcnt   (wcnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_wdata();
    return wm2reg ? wmo : walu;
  endfunction

  // Expected read value before the coming edge
  function automatic logic [31:0] exp_read(input logic [4:0] rn);
    if (!clrn || rn == 5'd0) return 32'd0;
`ifdef WB_BYPASS_EN
    if (wwreg && wrn == rn) return exp_wdata();
`endif
    return model_rf[rn];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) model_rf[i] = 32'd0;
    model_cnt = 32'd0;
  endtask

  // Check combinational outputs, take one rising edge, update the model
  task automatic cycle(input string tag);
    #1;
    check_eq({tag, ":wdata"}, wdata, exp_wdata());
    check_eq({tag, ":qa"}, qa, exp_read(rna));
    check_eq({tag, ":qb"}, qb, exp_read(rnb));
    check_eq({tag, ":wcnt"}, wcnt, model_cnt);
    @(posedge clk);
    if (clrn && wwreg && wrn != 5'd0) begin
      model_rf[wrn] = exp_wdata();
      model_cnt     = model_cnt + 32'd1;
    end
    #1;
  endtask

  task automatic idle_inputs();
    wwreg = 1'b0; wm2reg = 1'b0; walu = '0; wmo = '0; wrn = '0; rna = '0; rnb = '0;
  endtask

  task automatic do_write(input logic [4:0] rn, input logic [31:0] val);
    wwreg = 1'b1; wm2reg = 1'b0; walu = val; wrn = rn;
    cycle("wr");
    wwreg = 1'b0;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    model_reset();
    idle_inputs();
    clrn = 1'b0;
    #12;
    check_eq("rst_qa", qa, 32'd0);
    check_eq("rst_wcnt", wcnt, 32'd0);
    clrn = 1'b1;
    @(posedge clk); #1;

    // Dirty some state, then a short async reset pulse between edges
    do_write(5'd4, 32'hCAFE_0004);
    do_write(5'd31, 32'h0000_001F);
    #2 clrn = 1'b0;
    #1;
    check_eq("pulse_wcnt_async", wcnt, 32'd0);
    #1 clrn = 1'b1;
    model_reset();
    for (int i = 0; i < 32; i++) begin
      rna = 5'(i); rnb = 5'(31 - i);
      #1;
      check_eq("sweep_qa", qa, 32'd0);
      check_eq("sweep_qb", qb, 32'd0);
    end
    check_eq("sweep_wcnt", wcnt, 32'd0);
    @(posedge clk); #1;

    // Writeback mux selection
    wwreg = 1'b1; wrn = 5'd5; walu = 32'h1111_1111; wmo = 32'hAAAA_AAAA; wm2reg = 1'b1;
    cycle("mux_mem");
    wrn = 5'd6; wm2reg = 1'b0;
    cycle("mux_alu");
    wwreg = 1'b0; rna = 5'd5; rnb = 5'd6;
    #1;
    check_eq("mux_r5", qa, 32'hAAAA_AAAA);
    check_eq("mux_r6", qb, 32'h1111_1111);
    check_eq("mux_wcnt", wcnt, 32'd2);

    // Writes to r0 and disabled writes are discarded
    wwreg = 1'b1; wrn = 5'd0; walu = 32'hDEAD_BEEF; wm2reg = 1'b0; rna = 5'd0;
    cycle("r0_write");
    check_eq("r0_qa", qa, 32'd0);
    check_eq("r0_wcnt", wcnt, 32'd2);
    do_write(5'd7, 32'h7777_0007);
    wwreg = 1'b0; wrn = 5'd7; walu = 32'h0BAD_0BAD;
    cycle("noen");
    rna = 5'd7; #1;
    check_eq("noen_r7", qa, 32'h7777_0007);

    // Same-cycle read of the register being written
    do_write(5'd9, 32'h1234_5678);
    wwreg = 1'b1; wrn = 5'd9; walu = 32'h0BAD_F00D; wm2reg = 1'b0; rna = 5'd9; rnb = 5'd9;
    #1;
`ifdef WB_BYPASS_EN
    check_eq("byp_qa_pre", qa, 32'h0BAD_F00D);
    check_eq("byp_qb_pre", qb, 32'h0BAD_F00D);
`else
    check_eq("byp_qa_pre", qa, 32'h1234_5678);
    check_eq("byp_qb_pre", qb, 32'h1234_5678);
`endif
    cycle("byp");
    wwreg = 1'b0; #1;
    check_eq("byp_qa_post", qa, 32'h0BAD_F00D);
    check_eq("byp_qb_post", qb, 32'h0BAD_F00D);

    // Counter wrap via a preloaded count
    force dut.wcnt_q = 32'hFFFF_FFFF;
    #1 release dut.wcnt_q;
    model_cnt = 32'hFFFF_FFFF;
    #1;
    check_eq("wrap_preload", wcnt, 32'hFFFF_FFFF);
    do_write(5'd12, 32'h0000_0C0C);
    check_eq("wrap_zero", wcnt, 32'd0);

    // Reset held across an edge with a write pending
    @(negedge clk);
    wwreg = 1'b1; wrn = 5'd3; walu = 32'h3333_3333; wm2reg = 1'b0;
    clrn = 1'b0;
    model_reset();
    @(posedge clk); #2;
    wwreg = 1'b0;
    clrn = 1'b1;
    rna = 5'd3; rnb = 5'd12; #1;
    check_eq("rstwr_r3", qa, 32'd0);
    check_eq("rstwr_r12", qb, 32'd0);
    check_eq("rstwr_wcnt", wcnt, 32'd0);
    @(posedge clk); #1;

    // Randomized traffic, with occasional reset pulses between edges
    for (int n = 0; n < 400; n++) begin
      wwreg  = ($urandom_range(0, 3) != 0);
      wm2reg = $urandom_range(0, 1) == 1;
      walu   = $urandom;
      wmo    = $urandom;
      wrn    = 5'($urandom_range(0, 31));
      rna    = ($urandom_range(0, 3) == 0) ? wrn : 5'($urandom_range(0, 31));
      rnb    = ($urandom_range(0, 5) == 0) ? rna : 5'($urandom_range(0, 31));
      if ($urandom_range(0, 59) == 0) begin
        clrn = 1'b0;
        model_reset();
        #1;
        check_eq("rnd_rst_qa", qa, 32'd0);
        check_eq("rnd_rst_wcnt", wcnt, 32'd0);
        clrn = 1'b1;
      end
      cycle("rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wb_regfile.md
WB_REGFILE -- requirements
Module: wb_regfile

Interface
REQ-001 The block SHALL have exactly one clock and an asynchronous, active-low reset, with ports named as follows.
REQ-002 clk  input  1  Rising-edge clock for all state.
REQ-003 clrn  input  1  Asynchronous reset, active low; all state clears immediately.
REQ-004 wwreg  input  1  Writeback enable from the MEM/WB pipeline register.
REQ-005 wm2reg  input  1  Writeback source select: 1 = memory data, 0 = ALU result.
REQ-006 walu  input  32  ALU result from the MEM/WB pipeline register.
REQ-007 wmo  input  32  Memory load data from the MEM/WB pipeline register.
REQ-008 wrn  input  5  Destination register number.
REQ-009 rna  input  5  Read port A register number (ID stage).
REQ-010 rnb  input  5  Read port B register number (ID stage).
REQ-011 qa  output  32  Read port A data.
REQ-012 qb  output  32  Read port B data.
REQ-013 wdata  output  32  Selected writeback value, for forwarding to earlier stages.
REQ-014 wcnt  output  32  Count of committed register writes.

Function
REQ-015 wdata SHALL equal wmo when wm2reg=1 and walu when wm2reg=0, combinationally, regardless of wwreg.
REQ-016 Storage SHALL be 31 32-bit registers, r1..r31; r0 SHALL NOT be stored.
REQ-017 On a rising clk edge with clrn=1, wwreg=1 and wrn!=0, register[wrn] SHALL load wdata; no other register changes.
REQ-018 wwreg=0, or wwreg=1 with wrn=0, SHALL leave all registers unchanged (a write to r0 is discarded).
REQ-019 Reads SHALL be combinational, with zero-cycle latency: qa = register[rna] and qb = register[rnb].
REQ-020 rna=0 SHALL give qa=0, and rnb=0 SHALL give qb=0, unconditionally, including during a same-cycle write to r0.
REQ-021 rna=rnb SHALL give qa=qb.
REQ-022 A value written at edge N SHALL be readable from edge N onward, and SHALL persist until the next write to that register or the next reset.
REQ-023 wcnt SHALL increment by 1 on each rising edge that commits a write under REQ-017; it SHALL NOT increment for discarded writes.
REQ-024 wcnt SHALL wrap from 0xFFFFFFFF to 0x00000000 without saturation or flag.
REQ-025 Read/write conflicts, where rna or rnb equals wrn during the write cycle, SHALL be resolved per REQ-030 and REQ-031.

Reset
REQ-026 clrn=0 SHALL clear r1..r31 and wcnt to 0 asynchronously, without waiting for clk.
REQ-027 While clrn=0, qa and qb SHALL read 0 for every address, and writes SHALL be suppressed.
REQ-028 On reset deassertion, the first commit SHALL occur at the first rising edge that sees clrn=1 and satisfies REQ-017.
REQ-029 Reset asserted in the same cycle as a pending write SHALL win; the register stays 0 and wcnt stays 0.

Configuration
REQ-030 With WB_BYPASS_EN defined: when wwreg=1, wrn!=0 and rna=wrn, qa SHALL equal wdata combinationally in that cycle; the same rule SHALL apply to qb with rnb. This gives write-before-read semantics within one cycle.
REQ-031 With WB_BYPASS_EN undefined: qa and qb SHALL return the stored pre-edge value during the write cycle; the new value SHALL appear only after the edge.

Verification
REQ-032 Reset then read all: pulse clrn low mid-cycle, then sweep rna/rnb over 0..31 -> all reads 0, and wcnt=0 without any clk edge during the pulse.
REQ-033 Writeback mux: wwreg=1, wrn=5, walu=0x1111_1111, wmo=0xAAAA_AAAA, wm2reg=1, one edge -> rna=5 reads 0xAAAA_AAAA; repeat with wm2reg=0 and wrn=6 -> r6 reads 0x1111_1111; wcnt=2.
REQ-034 r0 discard: wwreg=1, wrn=0, walu=0xDEAD_BEEF, wm2reg=0, one edge -> qa at rna=0 is 0 and wcnt is unchanged; wwreg=0, wrn=7, one edge -> r7 is unchanged.
REQ-035 Same-cycle bypass: r9=0x1234_5678, then drive wwreg=1, wrn=9, walu=0x0BAD_F00D, wm2reg=0, rna=rnb=9 before the edge -> qa=qb=0x0BAD_F00D with WB_BYPASS_EN and 0x1234_5678 without it; both builds read 0x0BAD_F00D after the edge.
REQ-036 Counter wrap: commit 2^32-1 writes, or preload wcnt through a hierarchical force to 0xFFFF_FFFF, then commit one more write -> wcnt=0.
REQ-037 Reset mid-write: with wwreg=1, wrn=3 set up, assert clrn low across the rising edge -> r3=0 and wcnt=0 after release.
